irq_vector_sequencer: RTL and testbench



---
 rtl/irq_vector_sequencer.sv | 172 +++++++++++++++++
 tb/tb_irq_vector_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_vector_sequencer.sv
// Interrupt/reset vector sequencer for the 6502 core: arbitrates RESET, NMI, BRK and
// maskable IRQs at instruction boundaries, pushes PC/P, fetches the vector, loads PC.
module irq_vector_sequencer #(
  parameter int          IRQ_LINES = 4,
  parameter logic [15:0] NMI_VEC   = 16'hFFFA,
  parameter logic [15:0] RST_VEC   = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC   = 16'hFFFE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IRQ_LINES-1:0] irq_n,
  input  logic [IRQ_LINES-1:0] irq_mask,
  input  logic                 nmi_n,
  input  logic                 brk,
  input  logic                 boundary,
  input  logic [7:0]           P_in,
  input  logic [15:0]          PC_in,
  input  logic [7:0]           S_in,
  input  logic                 rdy,
  input  logic [7:0]           data_in,
  output logic                 busy,
  output logic                 bus_req,
  output logic [15:0]          bus_addr,
  output logic [7:0]           bus_dout,
  output logic                 mem_rw,
  output logic                 S_dec,
  output logic [15:0]          PC_out,
  output logic                 PC_ld,
  output logic                 set_I,
  output logic [3:0]           cause
);

  typedef enum logic [3:0] {
    RST_HOLD, RST_VL, RST_VH, IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_L, VEC_H, LOAD
  } state_t;

  localparam logic [3:0] CAUSE_BRK = 4'd8;
  localparam logic [3:0] CAUSE_NMI = 4'd9;
  localparam logic [3:0] CAUSE_RST = 4'd10;

  state_t      state, state_nx;
  logic        nmi_q, nmi_pend;
  logic        vec_nmi, is_brk;
  logic [3:0]  cause_q;
  logic        irq_any;
  logic [3:0]  irq_idx;
  logic        accept;
  logic [3:0]  accept_cause;
  logic [15:0] vec_base;
  logic [7:0]  pushed_p;

  // Scan from the top down so the lowest pending index is the one left standing.
  always_comb begin
    irq_any = 1'b0;
    irq_idx = '0;
    for (int k = IRQ_LINES - 1; k >= 0; k--) begin
      if (!irq_n[k] && irq_mask[k] && !P_in[2]) begin
        irq_any = 1'b1;
        irq_idx = 4'(k);
      end
    end
  end

  assign accept       = (state == IDLE) && boundary && (nmi_pend || brk || irq_any);
  assign accept_cause = nmi_pend ? CAUSE_NMI : (brk ? CAUSE_BRK : irq_idx);
  assign vec_base     = vec_nmi ? NMI_VEC : IRQ_VEC;
  assign pushed_p     = ((P_in | 8'h20) & 8'hEF) | {3'b000, is_brk, 4'b0000};

  // NOTE: every output and next-state gets a default before the case so no latch is inferred.
  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    bus_req  = 1'b0;
    bus_addr = '0;
    bus_dout = '0;
    mem_rw   = 1'b1;
    S_dec    = 1'b0;
    PC_ld    = 1'b0;
    set_I    = 1'b0;
    cause    = '0;
    case (state)
      RST_HOLD: state_nx = RST_VL;
      RST_VL: begin
        bus_req  = 1'b1;
        bus_addr = RST_VEC;
        if (rdy) state_nx = RST_VH;
      end
      RST_VH: begin
        bus_req  = 1'b1;
        bus_addr = RST_VEC + 16'd1;
        if (rdy) state_nx = LOAD;
      end
      IDLE: if (accept) state_nx = PUSH_PCH;
      PUSH_PCH: begin
        bus_req  = 1'b1;
        bus_addr = {8'h01, S_in};
        bus_dout = PC_in[15:8];
        mem_rw   = 1'b0;
        S_dec    = rdy;
        if (rdy) state_nx = PUSH_PCL;
      end
      PUSH_PCL: begin
        bus_req  = 1'b1;
        bus_addr = {8'h01, S_in};
        bus_dout = PC_in[7:0];
        mem_rw   = 1'b0;
        S_dec    = rdy;
        if (rdy) state_nx = PUSH_P;
      end
      PUSH_P: begin
        bus_req  = 1'b1;
        bus_addr = {8'h01, S_in};
        bus_dout = pushed_p;
        mem_rw   = 1'b0;
        S_dec    = rdy;
        if (rdy) state_nx = VEC_L;
      end
      VEC_L: begin
        bus_req  = 1'b1;
        bus_addr = vec_base;
        if (rdy) state_nx = VEC_H;
      end
      VEC_H: begin
        bus_req  = 1'b1;
        bus_addr = vec_base + 16'd1;
        if (rdy) state_nx = LOAD;
      end
      LOAD: begin
        PC_ld    = 1'b1;
        set_I    = 1'b1;
        cause    = cause_q;
        state_nx = IDLE;
      end
      default: state_nx = RST_HOLD;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RST_HOLD;
      nmi_q    <= 1'b1;
      nmi_pend <= 1'b0;
      vec_nmi  <= 1'b0;
      is_brk   <= 1'b0;
      cause_q  <= CAUSE_RST;
      PC_out   <= '0;
    end else begin
      state <= state_nx;
      nmi_q <= nmi_n;
      // A fresh edge wins over the clear so it is never lost.
      if (nmi_q && !nmi_n)
        nmi_pend <= 1'b1;
      else if (state == VEC_L && rdy && vec_nmi)
        nmi_pend <= 1'b0;

      if (accept) begin
        vec_nmi <= nmi_pend;
        is_brk  <= !nmi_pend && brk;
        cause_q <= accept_cause;
      end else if ((state inside {PUSH_PCH, PUSH_PCL, PUSH_P}) && nmi_pend && !vec_nmi) begin
        // NMI hijack: redirect the vector, leave the pushed B bit alone.
        vec_nmi <= 1'b1;
        cause_q <= CAUSE_NMI;
      end

      if ((state == RST_VL || state == VEC_L) && rdy) PC_out[7:0]  <= data_in;
      if ((state == RST_VH || state == VEC_H) && rdy) PC_out[15:8] <= data_in;
    end
  end

endmodule

// File: tb/tb_irq_vector_sequencer.sv
// Bench for irq_vector_sequencer: directed scenarios plus randomized events checked
// against an arbitration/stack model; a tiny core model applies S_dec to S_in.
module tb_irq_vector_sequencer;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_n, irq_mask;
  logic          nmi_n, brk, boundary;
  logic [7:0]    P_in;
  logic [15:0]   PC_in;
  logic [7:0]    S_in;
  logic          rdy;
  logic [7:0]    data_in;
  logic          busy, bus_req, mem_rw, S_dec, PC_ld, set_I;
  logic [15:0]   bus_addr, PC_out;
  logic [7:0]    bus_dout;
  logic [3:0]    cause;

  logic [7:0]    mem [0:65535];
  assign data_in = mem[bus_addr];

  int total = 0;
  int bad   = 0;

  // Results gathered by run_seq
  logic [23:0] wr_q[$];
  logic [15:0] rd_q[$];
  bit          got_ld;
  int          ld_tick, stall_cnt, stall_diff, sdec_cnt;
  logic [15:0] ld_pc;
  logic [3:0]  ld_cause;
  logic        ld_seti, post_busy, busy1, acc_busy;

  irq_vector_sequencer #(.IRQ_LINES(N)) dut (
    .clk(clk), .rst(rst), .irq_n(irq_n), .irq_mask(irq_mask), .nmi_n(nmi_n),
    .brk(brk), .boundary(boundary), .P_in(P_in), .PC_in(PC_in), .S_in(S_in),
    .rdy(rdy), .data_in(data_in), .busy(busy), .bus_req(bus_req),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .mem_rw(mem_rw), .S_dec(S_dec),
    .PC_out(PC_out), .PC_ld(PC_ld), .set_I(set_I), .cause(cause)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int model_cause(bit nmi, bit b, logic [N-1:0] irqn,
                                     logic [N-1:0] msk, logic [7:0] p);
    if (nmi) return 9;
    if (b) return 8;
    if (!p[2])
      for (int k = 0; k < N; k++)
        if (!irqn[k] && msk[k]) return k;
    return -1;
  endfunction

  function automatic logic [15:0] model_vec(int c);
    if (c == 9)  return 16'hFFFA;
    if (c == 10) return 16'hFFFC;
    return 16'hFFFE;
  endfunction

  function automatic logic [7:0] model_p(logic [7:0] p, bit b_flag);
    return ((p | 8'h20) & 8'hEF) | (b_flag ? 8'h10 : 8'h00);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents boundary for one cycle; irq lines drop right after acceptance.
  task automatic accept();
    boundary = 1'b1;
    @(negedge clk);
    acc_busy = busy;
    @(posedge clk); #1;
    boundary = 1'b0;
    brk      = 1'b0;
    irq_n    = '1;
  endtask

  // Steps until PC_ld (cycle 1 = first cycle after the call), logging bus traffic.
  task automatic run_seq(input int budget, input int stall_from, input int stall_len,
                         input bit rand_stall, input int nmi_tick);
    bit          prev_stall = 1'b0;
    bit          dec;
    logic [25:0] snap = '0;
    wr_q.delete(); rd_q.delete();
    got_ld = 1'b0; ld_tick = 0; stall_cnt = 0; stall_diff = 0; sdec_cnt = 0;
    ld_pc = '0; ld_cause = '0; ld_seti = 1'b0; busy1 = 1'b0;
    for (int k = 1; k <= budget && !got_ld; k++) begin
      if (k >= stall_from && k < stall_from + stall_len) rdy = 1'b0;
      else if (rand_stall) rdy = ($urandom_range(0, 3) != 0);
      else rdy = 1'b1;
      if (k == nmi_tick) nmi_n = 1'b0;
      if (k == nmi_tick + 2) nmi_n = 1'b1;
      @(negedge clk);
      if (k == 1) busy1 = busy;
      if (prev_stall && {bus_req, mem_rw, bus_addr, bus_dout} !== snap) stall_diff++;
      prev_stall = bus_req && !rdy;
      snap = {bus_req, mem_rw, bus_addr, bus_dout};
      if (prev_stall) stall_cnt++;
      if (bus_req && rdy && !mem_rw) wr_q.push_back({bus_addr, bus_dout});
      if (bus_req && rdy && mem_rw) rd_q.push_back(bus_addr);
      dec = S_dec;
      if (dec) sdec_cnt++;
      if (PC_ld) begin
        got_ld = 1'b1; ld_tick = k; ld_pc = PC_out; ld_cause = cause; ld_seti = set_I;
      end
      @(posedge clk); #1;
      if (dec) S_in = S_in - 8'd1;
    end
    rdy = 1'b1; nmi_n = 1'b1;
    @(negedge clk);
    post_busy = busy;
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    rst = 1'b1;
    repeat (3) step();
    total++; if ({busy, mem_rw, bus_req, PC_ld, set_I, S_dec} !== 6'b110000) begin bad++; $display("FAIL rst_ctrl got=%b want=110000", {busy, mem_rw, bus_req, PC_ld, set_I, S_dec}); end
    total++; if ({bus_addr, bus_dout, PC_out, cause} !== 44'h0) begin bad++; $display("FAIL rst_data got=%h want=0", {bus_addr, bus_dout, PC_out, cause}); end
    rst = 1'b0;
    run_seq(20, 0, 0, 1'b0, -10);
    total++; if (!got_ld || ld_tick != 4) begin bad++; $display("FAIL rst_latency got=%0d want=4", ld_tick); end
    total++; if (ld_pc !== 16'h1234) begin bad++; $display("FAIL rst_pc got=%h want=1234", ld_pc); end
    total++; if (ld_cause !== 4'd10 || ld_seti !== 1'b1) begin bad++; $display("FAIL rst_cause got=%0d/%b want=10/1", ld_cause, ld_seti); end
    total++; if (wr_q.size() != 0 || sdec_cnt != 0) begin bad++; $display("FAIL rst_nowrite got=%0d/%0d want=0/0", wr_q.size(), sdec_cnt); end
    total++; if (post_busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy got=%b want=0", post_busy); end
  endtask

  task automatic test_irq_line2();
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h80;
    irq_n = 4'b1011; irq_mask = 4'hF; P_in = 8'h00; PC_in = 16'hC005; S_in = 8'hFD;
    accept();
    run_seq(30, 0, 0, 1'b0, -10);
    total++; if (acc_busy !== 1'b0 || busy1 !== 1'b1) begin bad++; $display("FAIL irq2_busy_rise got=%b%b want=01", acc_busy, busy1); end
    total++; if (wr_q.size() != 3) begin bad++; $display("FAIL irq2_nwr got=%0d want=3", wr_q.size()); end
    total++; if (wr_q[0] !== 24'h01FDC0) begin bad++; $display("FAIL irq2_wr0 got=%h want=01fdc0", wr_q[0]); end
    total++; if (wr_q[1] !== 24'h01FC05) begin bad++; $display("FAIL irq2_wr1 got=%h want=01fc05", wr_q[1]); end
    total++; if (wr_q[2] !== 24'h01FB20) begin bad++; $display("FAIL irq2_wr2 got=%h want=01fb20", wr_q[2]); end
    total++; if (ld_pc !== 16'h8000 || ld_cause !== 4'd2 || ld_seti !== 1'b1) begin bad++; $display("FAIL irq2_load got=%h/%0d/%b want=8000/2/1", ld_pc, ld_cause, ld_seti); end
    total++; if (ld_tick != 6) begin bad++; $display("FAIL irq2_latency got=%0d want=6", ld_tick); end
    total++; if (S_in !== 8'hFA || sdec_cnt != 3) begin bad++; $display("FAIL irq2_sdec got=%h/%0d want=fa/3", S_in, sdec_cnt); end
  endtask

  task automatic test_priority();
    irq_mask = 4'hF; PC_in = 16'h1000; S_in = 8'hF0;
    irq_n = 4'b0110; brk = 1'b1; P_in = 8'h00;
    accept(); run_seq(30, 0, 0, 1'b0, -10);
    total++; if (ld_cause !== 4'd8 || wr_q[2][7:0] !== 8'h30) begin bad++; $display("FAIL prio_brk got=%0d/%h want=8/30", ld_cause, wr_q[2][7:0]); end
    irq_n = 4'b0110; brk = 1'b1; P_in = 8'h04;
    accept(); run_seq(30, 0, 0, 1'b0, -10);
    total++; if (ld_cause !== 4'd8 || wr_q[2][7:0] !== 8'h34) begin bad++; $display("FAIL prio_brk_I got=%0d/%h want=8/34", ld_cause, wr_q[2][7:0]); end
    irq_n = 4'b0110; brk = 1'b0; P_in = 8'h04;
    accept();
    @(negedge clk);
    total++; if (busy !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL prio_masked got=%b%b want=00", busy, bus_req); end
    step();
    irq_n = 4'b0110; brk = 1'b0; P_in = 8'h00;
    accept(); run_seq(30, 0, 0, 1'b0, -10);
    total++; if (ld_cause !== 4'd0) begin bad++; $display("FAIL prio_line0 got=%0d want=0", ld_cause); end
  endtask

  task automatic test_nmi_hijack();
    mem[16'hFFFA] = 8'hCD; mem[16'hFFFB] = 8'hAB;
    irq_n = 4'b1110; irq_mask = 4'hF; P_in = 8'h00; PC_in = 16'h2345; S_in = 8'hE0;
    accept(); run_seq(30, 0, 0, 1'b0, 2);
    total++; if (rd_q.size() != 2 || rd_q[0] !== 16'hFFFA || rd_q[1] !== 16'hFFFB) begin bad++; $display("FAIL hijack_vec got=%h want=fffa", rd_q[0]); end
    total++; if (ld_pc !== 16'hABCD || ld_cause !== 4'd9) begin bad++; $display("FAIL hijack_load got=%h/%0d want=abcd/9", ld_pc, ld_cause); end
    total++; if (wr_q[2][7:0] !== 8'h20) begin bad++; $display("FAIL hijack_pushed_p got=%h want=20", wr_q[2][7:0]); end
    irq_n = '1;
    accept();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hijack_no_second got=%b want=0", busy); end
    step();
  endtask

  task automatic test_rdy_stall();
    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22;
    irq_n = 4'b1101; irq_mask = 4'hF; P_in = 8'hC3; PC_in = 16'h4567; S_in = 8'h80;
    accept(); run_seq(30, 3, 3, 1'b0, -10);
    total++; if (ld_tick != 9) begin bad++; $display("FAIL stall_latency got=%0d want=9", ld_tick); end
    total++; if (stall_diff != 0 || stall_cnt != 3) begin bad++; $display("FAIL stall_hold got=%0d/%0d want=0/3", stall_diff, stall_cnt); end
    total++; if (sdec_cnt != 3 || wr_q.size() != 3) begin bad++; $display("FAIL stall_sdec got=%0d/%0d want=3/3", sdec_cnt, wr_q.size()); end
    total++; if (wr_q[2] !== {16'h017E, 8'hE3} || ld_cause !== 4'd1 || ld_pc !== 16'h2211) begin bad++; $display("FAIL stall_data got=%h/%0d/%h want=017ee3/1/2211", wr_q[2], ld_cause, ld_pc); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] addr_vl;
    irq_n = 4'b1110; irq_mask = 4'hF; P_in = 8'h00; PC_in = 16'h0300; S_in = 8'hFF;
    accept();
    repeat (3) step();
    @(negedge clk);
    addr_vl = bus_addr;
    #1 rst = 1'b1;
    #1;
    total++; if (addr_vl !== 16'hFFFE) begin bad++; $display("FAIL midrst_in_vecl got=%h want=fffe", addr_vl); end
    total++; if ({busy, mem_rw, bus_req, PC_ld, S_dec} !== 5'b11000 || bus_addr !== 16'h0 || PC_out !== 16'h0) begin bad++; $display("FAIL midrst_async got=%b/%h/%h want=11000/0/0", {busy, mem_rw, bus_req, PC_ld, S_dec}, bus_addr, PC_out); end
    mem[16'hFFFC] = 8'h78; mem[16'hFFFD] = 8'h56;
    step();
    rst = 1'b0;
    run_seq(20, 0, 0, 1'b0, -10);
    total++; if (ld_tick != 4 || ld_pc !== 16'h5678 || ld_cause !== 4'd10) begin bad++; $display("FAIL midrst_restart got=%0d/%h/%0d want=4/5678/10", ld_tick, ld_pc, ld_cause); end
  endtask

  task automatic test_random();
    int          c;
    bit          mk_nmi, b;
    logic [7:0]  s0, p0;
    logic [15:0] pc0, v, exp_pc;
    logic [23:0] exp_wr [3];
    for (int it = 0; it < 40; it++) begin
      irq_n = N'($urandom); irq_mask = N'($urandom);
      p0 = 8'($urandom); pc0 = 16'($urandom); s0 = 8'($urandom);
      b = ($urandom_range(0, 3) == 0); mk_nmi = ($urandom_range(0, 4) == 0);
      for (int a = 16'hFFFA; a <= 16'hFFFF; a++) mem[a] = 8'($urandom);
      P_in = p0; PC_in = pc0; S_in = s0; brk = b;
      c = model_cause(mk_nmi, b, irq_n, irq_mask, p0);
      if (mk_nmi) begin
        nmi_n = 1'b0; step(); step(); nmi_n = 1'b1; step();
      end
      accept();
      if (c < 0) begin
        @(negedge clk);
        total++; if (busy !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL rnd%0d_idle got=%b%b want=00", it, busy, bus_req); end
        step();
      end else begin
        run_seq(80, 0, 0, 1'b1, -10);
        v = model_vec(c);
        exp_pc = {mem[v + 16'd1], mem[v]};
        exp_wr[0] = {8'h01, s0, pc0[15:8]};
        exp_wr[1] = {8'h01, s0 - 8'd1, pc0[7:0]};
        exp_wr[2] = {8'h01, s0 - 8'd2, model_p(p0, c == 8)};
        total++; if (!got_ld || ld_tick != 6 + stall_cnt) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", it, ld_tick, 6 + stall_cnt); end
        total++; if (ld_cause !== 4'(c) || ld_seti !== 1'b1) begin bad++; $display("FAIL rnd%0d_cause got=%0d want=%0d", it, ld_cause, c); end
        total++; if (ld_pc !== exp_pc) begin bad++; $display("FAIL rnd%0d_pc got=%h want=%h", it, ld_pc, exp_pc); end
        total++; if (wr_q.size() != 3 || sdec_cnt != 3) begin bad++; $display("FAIL rnd%0d_nwr got=%0d/%0d want=3/3", it, wr_q.size(), sdec_cnt); end
        for (int i = 0; i < 3; i++) begin
          total++; if (wr_q[i] !== exp_wr[i]) begin bad++; $display("FAIL rnd%0d_wr%0d got=%h want=%h", it, i, wr_q[i], exp_wr[i]); end
        end
        total++; if (rd_q.size() != 2 || rd_q[0] !== v || rd_q[1] !== v + 16'd1) begin bad++; $display("FAIL rnd%0d_rd got=%h want=%h", it, rd_q[0], v); end
        total++; if (stall_diff != 0 || post_busy !== 1'b0) begin bad++; $display("FAIL rnd%0d_hold got=%0d/%b want=0/0", it, stall_diff, post_busy); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; irq_n = '1; irq_mask = '1; nmi_n = 1'b1; brk = 1'b0; boundary = 1'b0;
    P_in = 8'h00; PC_in = 16'h0000; S_in = 8'hFF; rdy = 1'b1;
    test_reset();
    test_irq_line2();
    test_priority();
    test_nmi_hijack();
    test_rdy_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
